// File: rtl/serial_rx_checker.sv
// 8N1 UART receiver that checks the received bytes against the rolling ASCII digit sequence '1'..'9','0',...
// o_valid is about 2 + 4p + 72p clocks after the start edge; there is no backpressure, so each byte is reported once as a one-cycle pulse.
module serial_rx_checker #(
  parameter int SERIAL_DATA_SIZE = 8,
  parameter int PRESCALE_SIZE    = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_serial,
  input  logic [PRESCALE_SIZE-1:0]    i_prescale,
  output logic [SERIAL_DATA_SIZE-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_frame_error,
  output logic                        o_seq_error,
  output logic                        o_busy,
  output logic [15:0]                 o_good_count
);

  localparam int TW = PRESCALE_SIZE + 3;
  localparam int IW = (SERIAL_DATA_SIZE > 1) ? $clog2(SERIAL_DATA_SIZE) : 1;
  localparam logic [SERIAL_DATA_SIZE-1:0] ASCII_0 = SERIAL_DATA_SIZE'(8'h30);
  localparam logic [SERIAL_DATA_SIZE-1:0] ASCII_9 = SERIAL_DATA_SIZE'(8'h39);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                      state_q;
  logic                        sync1_q;
  logic                        rx_s_q;
  logic [PRESCALE_SIZE-1:0]    p_q;
  logic [TW-1:0]               timer_q;
  logic [IW-1:0]               bit_idx_q;
  logic [SERIAL_DATA_SIZE-1:0] shift_q;
  logic [SERIAL_DATA_SIZE-1:0] prev_q;
  logic                        seeded_q;
  logic [SERIAL_DATA_SIZE-1:0] data_q;
  logic                        valid_q;
  logic                        ferr_q;
  logic                        serr_q;
  logic                        busy_q;
  logic [15:0]                 good_q;

  logic [PRESCALE_SIZE-1:0]    p_d;
  logic [TW-1:0]               half_load_d;
  logic [TW-1:0]               full_load_d;
  logic                        timer_done;
  logic                        in_range;
  logic [SERIAL_DATA_SIZE-1:0] expect_d;
  logic [15:0]                 good_inc_d;

  // Loads are N-1 so that each interval lasts exactly N clocks, with expiry at zero.
  assign p_d         = (i_prescale == '0) ? PRESCALE_SIZE'(1) : i_prescale;
  assign half_load_d = {1'b0, p_d, 2'b00} - TW'(1);
  assign full_load_d = {p_q, 3'b000} - TW'(1);
  assign timer_done  = (timer_q == '0);

  assign in_range   = (shift_q >= ASCII_0) && (shift_q <= ASCII_9);
  assign expect_d   = (prev_q == ASCII_9) ? ASCII_0 : prev_q + SERIAL_DATA_SIZE'(1);
  assign good_inc_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      p_q       <= PRESCALE_SIZE'(1);
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      prev_q    <= '0;
      seeded_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      serr_q    <= 1'b0;
      busy_q    <= 1'b0;
      good_q    <= '0;
    end else begin
      sync1_q <= i_serial;
      rx_s_q  <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      serr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            p_q     <= p_d;
            timer_q <= half_load_d;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (!timer_done) begin
            timer_q <= timer_q - TW'(1);
          end else if (!rx_s_q) begin
            timer_q   <= full_load_d;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DATA: begin
          if (!timer_done) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            shift_q <= {rx_s_q, shift_q[SERIAL_DATA_SIZE-1:1]};
            timer_q <= full_load_d;
            if (bit_idx_q == IW'(SERIAL_DATA_SIZE - 1)) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + IW'(1);
            end
          end
        end
        STOP: begin
          if (!timer_done) begin
            timer_q <= timer_q - TW'(1);
          end else if (rx_s_q) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            // A non-digit drops the seed so the next digit restarts the sequence.
            if (!in_range) begin
              serr_q   <= 1'b1;
              seeded_q <= 1'b0;
            end else if (!seeded_q) begin
              prev_q   <= shift_q;
              seeded_q <= 1'b1;
              good_q   <= good_inc_d;
            end else if (shift_q == expect_d) begin
              prev_q <= shift_q;
              good_q <= good_inc_d;
            end else begin
              prev_q <= shift_q;
              serr_q <= 1'b1;
            end
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;
  assign o_seq_error   = serr_q;
  assign o_busy        = busy_q;
  assign o_good_count  = good_q;

endmodule

// File: tb/tb_serial_rx_checker.sv
// Directed bench for serial_rx_checker: frames are driven bit by bit and outputs are checked against hand-computed values.
module tb_serial_rx_checker;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_serial;
  logic [15:0] i_prescale;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_error;
  logic        o_seq_error;
  logic        o_busy;
  logic [15:0] o_good_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int serr_cnt = 0;
  int busy_seen = 0;
  int last_valid_cyc = 0;
  logic [7:0] vlog [0:63];
  int v0, f0, s0, b0;

  serial_rx_checker #(.SERIAL_DATA_SIZE(8), .PRESCALE_SIZE(16)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_serial      (i_serial),
    .i_prescale    (i_prescale),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_frame_error (o_frame_error),
    .o_seq_error   (o_seq_error),
    .o_busy        (o_busy),
    .o_good_count  (o_good_count)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  always @(negedge i_clock) begin
    if (o_valid) begin
      vlog[valid_cnt[5:0]] <= o_data;
      valid_cnt <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (o_frame_error) ferr_cnt <= ferr_cnt + 1;
    if (o_seq_error) serr_cnt <= serr_cnt + 1;
    if (o_busy) busy_seen <= busy_seen + 1;
  end

  task automatic snap();
    v0 = valid_cnt; f0 = ferr_cnt; s0 = serr_cnt; b0 = busy_seen;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen);
    i_serial = 1'b0;
    repeat (bitlen) @(posedge i_clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_serial = b[i];
      repeat (bitlen) @(posedge i_clock);
      #1;
    end
    i_serial = stop;
    repeat (bitlen) @(posedge i_clock);
    #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b0;
    i_serial = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", o_frame_error); end
    checks++; if (o_seq_error !== 1'b0) begin errors++; $display("FAIL reset_serr: got %b expected 0", o_seq_error); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_good_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_good_count); end
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock); #1;
  endtask

  task automatic test_single();
    int start_cyc, lat;
    snap();
    start_cyc = cyc;
    send_frame(8'h31, 1'b1, 16);
    repeat (2) @(posedge i_clock); #1;
    lat = last_valid_cyc - start_cyc;
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    checks++; if (o_data !== 8'h31) begin errors++; $display("FAIL single_data: got %h expected 31", o_data); end
    checks++; if (serr_cnt != s0) begin errors++; $display("FAIL single_seq: got %0d expected 0", serr_cnt - s0); end
    checks++; if (o_good_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", o_good_count); end
    checks++; if (lat < 153 || lat > 155) begin errors++; $display("FAIL single_latency: got %0d expected 154+-1", lat); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    snap();
    send_frame(8'h38, 1'b1, 16);
    send_frame(8'h39, 1'b1, 16);
    send_frame(8'h30, 1'b1, 16);
    send_frame(8'h31, 1'b1, 16);
    repeat (4) @(posedge i_clock); #1;
    checks++; if (valid_cnt - v0 != 4) begin errors++; $display("FAIL b2b_valid: got %0d expected 4", valid_cnt - v0); end
    checks++; if (serr_cnt != s0) begin errors++; $display("FAIL b2b_seq: got %0d expected 0", serr_cnt - s0); end
    checks++; if (o_good_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", o_good_count); end
    checks++; if (vlog[(v0 + 2) % 64] !== 8'h30) begin errors++; $display("FAIL b2b_wrap_byte: got %h expected 30", vlog[(v0 + 2) % 64]); end
  endtask

  task automatic test_seq_error();
    apply_reset();
    snap();
    send_frame(8'h33, 1'b1, 16);
    send_frame(8'h35, 1'b1, 16);
    repeat (2) @(posedge i_clock); #1;
    checks++; if (serr_cnt - s0 != 1) begin errors++; $display("FAIL seq_err_pulse: got %0d expected 1", serr_cnt - s0); end
    checks++; if (o_good_count !== 16'd1) begin errors++; $display("FAIL seq_err_count: got %0d expected 1", o_good_count); end
    snap();
    send_frame(8'h36, 1'b1, 16);
    repeat (2) @(posedge i_clock); #1;
    checks++; if (serr_cnt != s0) begin errors++; $display("FAIL seq_reseed_err: got %0d expected 0", serr_cnt - s0); end
    checks++; if (o_good_count !== 16'd2) begin errors++; $display("FAIL seq_reseed_count: got %0d expected 2", o_good_count); end
  endtask

  task automatic test_frame_error();
    snap();
    send_frame(8'h32, 1'b0, 16);
    repeat (24) @(posedge i_clock); #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b expected 1", o_busy); end
    i_serial = 1'b1;
    repeat (4) @(posedge i_clock); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b expected 0", o_busy); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (o_data !== 8'h36) begin errors++; $display("FAIL ferr_data_kept: got %h expected 36", o_data); end
    snap();
    send_frame(8'h37, 1'b1, 16);
    repeat (2) @(posedge i_clock); #1;
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL ferr_next_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (o_data !== 8'h37) begin errors++; $display("FAIL ferr_next_data: got %h expected 37", o_data); end
    checks++; if (serr_cnt != s0) begin errors++; $display("FAIL ferr_next_seq: got %0d expected 0", serr_cnt - s0); end
    checks++; if (o_good_count !== 16'd3) begin errors++; $display("FAIL ferr_next_count: got %0d expected 3", o_good_count); end
  endtask

  task automatic test_glitch();
    snap();
    i_serial = 1'b0;
    repeat (4) @(posedge i_clock); #1;
    i_serial = 1'b1;
    repeat (7) @(posedge i_clock); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", o_busy); end
    checks++; if (busy_seen == b0) begin errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles expected >0"); end
    repeat (20) @(posedge i_clock); #1;
    checks++; if (valid_cnt != v0 || ferr_cnt != f0 || serr_cnt != s0) begin
      errors++; $display("FAIL glitch_pulses: got v%0d f%0d s%0d expected none", valid_cnt - v0, ferr_cnt - f0, serr_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    snap();
    i_serial = 1'b0; repeat (16) @(posedge i_clock); #1;
    i_serial = 1'b1; repeat (26) @(posedge i_clock); #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", o_busy); end
    i_reset = 1'b0;
    #2;
    checks++; if (o_data !== 8'h00 || o_good_count !== 16'd0) begin
      errors++; $display("FAIL rmid_data_count: got %h/%0d expected 00/0", o_data, o_good_count);
    end
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_frame_error !== 1'b0 || o_seq_error !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: got b%b v%b f%b s%b expected 0", o_busy, o_valid, o_frame_error, o_seq_error);
    end
    i_serial = 1'b1;
    repeat (3) @(posedge i_clock); #1;
    i_reset = 1'b1;
    repeat (40) @(posedge i_clock); #1;
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL rmid_no_valid: got %0d expected 0", valid_cnt - v0); end
    snap();
    send_frame(8'h34, 1'b1, 16);
    repeat (2) @(posedge i_clock); #1;
    checks++; if (o_data !== 8'h34) begin errors++; $display("FAIL rmid_next_data: got %h expected 34", o_data); end
    checks++; if (o_good_count !== 16'd1) begin errors++; $display("FAIL rmid_next_count: got %0d expected 1", o_good_count); end
    checks++; if (serr_cnt != s0) begin errors++; $display("FAIL rmid_next_seq: got %0d expected 0", serr_cnt - s0); end
  endtask

  task automatic test_loopback();
    logic [7:0] seq [0:11];
    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30, 8'h31, 8'h32};
    apply_reset();
    snap();
    for (int j = 0; j < 12; j++) send_frame(seq[j], 1'b1, 16);
    repeat (4) @(posedge i_clock); #1;
    checks++; if (valid_cnt - v0 != 12) begin errors++; $display("FAIL loop_valid: got %0d expected 12", valid_cnt - v0); end
    for (int j = 0; j < 12; j++) begin
      checks++; if (vlog[(v0 + j) % 64] !== seq[j]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", j, vlog[(v0 + j) % 64], seq[j]); end
    end
    checks++; if (serr_cnt != s0 || ferr_cnt != f0) begin errors++; $display("FAIL loop_errors: got s%0d f%0d expected 0", serr_cnt - s0, ferr_cnt - f0); end
    checks++; if (o_good_count !== 16'd12) begin errors++; $display("FAIL loop_count: got %0d expected 12", o_good_count); end
  endtask

  task automatic test_prescale_zero();
    snap();
    i_prescale = 16'd0;
    fork
      send_frame(8'h33, 1'b1, 8);
      begin repeat (30) @(posedge i_clock); #1; i_prescale = 16'd7; end
    join
    repeat (2) @(posedge i_clock); #1;
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL pz_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (o_data !== 8'h33) begin errors++; $display("FAIL pz_data: got %h expected 33", o_data); end
    checks++; if (o_good_count !== 16'd13) begin errors++; $display("FAIL pz_count: got %0d expected 13", o_good_count); end
    i_prescale = 16'd2;
  endtask

  initial begin
    i_reset = 1'b1;
    i_serial = 1'b1;
    i_prescale = 16'd2;
    #3 i_reset = 1'b0;
    #20;
    test_reset();
    test_single();
    test_back_to_back();
    test_seq_error();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    test_loopback();
    test_prescale_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/serial_rx_checker.md
Name: serial_rx_checker

Overview:
- Receive-side companion to the digit-stream transmitter. It deserializes the 8N1 UART line that stage drives, using the same prescale convention (bit period = 8 × prescale clocks; 16'h0516 gives 9600 baud).
- It checks that received bytes follow the ASCII digit sequence '1'..'9','0','1'... that the transmitter produces.
- Used in loopback self-test and on the board to confirm link integrity.

Parameters:
- SERIAL_DATA_SIZE, 8, data bits per frame; LSB first.
- PRESCALE_SIZE, 16, width of i_prescale.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_serial  in  1  UART line; idle high; asynchronous to i_clock.
- i_prescale  in  PRESCALE_SIZE  bit period = 8 × i_prescale clocks; value 0 is treated as 1.
- o_data  out  SERIAL_DATA_SIZE  last correctly framed byte.
- o_valid  out  1  one-cycle pulse when o_data updates.
- o_frame_error  out  1  one-cycle pulse when the stop bit is sampled low.
- o_seq_error  out  1  one-cycle pulse when a valid byte breaks the digit sequence.
- o_busy  out  1  high in every state except IDLE.
- o_good_count  out  16  count of bytes passing the sequence check; saturates at 16'hFFFF.

Behaviour:
- Reset (i_reset low, async):
  - o_data=0, o_valid=0, o_frame_error=0, o_seq_error=0, o_busy=0, o_good_count=0.
  - Synchronizer flops = 1, state=IDLE, seed flag cleared.
- Input path: 2-flop synchronizer on i_serial; all decisions use the second flop (rx_s).
- Bit timer: 19-bit down-counter. HALF = 4 × p and FULL = 8 × p, where p = latched prescale.
- State machine:
  - IDLE: rx_s==0 → latch p from i_prescale (0→1), load HALF, go to START.
  - START: at timer expiry, sample rx_s. If 0, load FULL, clear bit index, go to DATA. If 1, it is a false start: return to IDLE with no output pulse.
  - DATA: at each expiry, shift rx_s into the MSB of the shift register (LSB-first assembly) and reload FULL. After SERIAL_DATA_SIZE samples, go to STOP.
  - STOP: at expiry, sample rx_s.
    - If 1: o_data ← shift register, o_valid=1 for one cycle, go to IDLE.
    - If 0: o_frame_error=1 for one cycle, o_data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This covers breaks and a line held low.
- Latency: o_valid rises 2 sync cycles + 4p + 8p × (SERIAL_DATA_SIZE+1) clocks after the falling start edge at the pin, ±1 cycle.
- Back-to-back frames: a start edge in the cycle after the return to IDLE is accepted. No idle gap is required beyond the stop bit.
- i_prescale changes mid-frame have no effect until the next start detect.
- Sequence checker, evaluated in the o_valid cycle; errors and count update in that same cycle:
  - Byte outside 8'h30..8'h39: o_seq_error pulse, seed flag cleared, count unchanged.
  - Seed flag clear: store the byte as prev, set the seed flag, increment count. No error, so the first digit is accepted whatever its value.
  - Otherwise expected = (prev==8'h39) ? 8'h30 : prev+1.
    - Match: increment count (saturating), prev ← byte.
    - Mismatch: o_seq_error pulse, prev ← byte (reseed), count unchanged.
- Frame errors do not touch prev, the seed flag or the count.
- Reset mid-frame: returns immediately to the reset values. Any partial byte is discarded, with no output pulse.

Test Plan:
- Prescale=2 (16 clk/bit): drive frame 8'h31 → single o_valid, o_data=8'h31, o_seq_error=0, o_good_count=1. Latency matches the formula ±1.
- Prescale=2: send '8','9','0','1' back-to-back with no idle gap → four o_valid pulses, no o_seq_error, count=4. Confirms the '9'→'0' wrap.
- Send '3' then '5' → o_seq_error on '5', count=1. Then send '6' → no error, count=2 (reseeded on '5').
- Frame 8'h32 with stop bit low, line held low for 40 clocks → o_frame_error pulse, no o_valid, o_data unchanged. o_busy stays high until the line returns high; the next good frame is received normally.
- Glitch: line low for 4 clocks only at prescale=2 → false start, no pulses, o_busy back to 0 within 11 clocks.
- Assert i_reset low mid-DATA of frame 8'h37 → all outputs 0 immediately. After release, a new '4' frame gives o_data=8'h34, count=1, no seq error.
- Loopback: connect the transmitter's output to i_serial at prescale 16'h0516 with 12 start pulses → 12 o_valid pulses, bytes '1'..'9','0','1','2', no errors, count=12.
